// File: rtl/ext_mem_pkg.sv
// Shared constants, state/direction types and the burst range check for the
// external-memory DMA initiator.
package ext_mem_pkg;

  localparam int EXT_AW    = 24;
  localparam int DW        = 32;
  localparam int LOC_AW    = 12;
  localparam int LEN_W     = 16;
  localparam int EXT_WORDS = 1 << 23;

  // Region bases inside external memory: model weights, then input data.
  localparam logic [EXT_AW-1:0] MODEL_BASE = 24'h000000;
  localparam logic [EXT_AW-1:0] INPUT_BASE = 24'h400000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } dma_state_e;

  typedef enum logic {
    DIR_LOAD  = 1'b0,
    DIR_STORE = 1'b1
  } dma_dir_e;

  // True when every word of the burst lies below EXT_WORDS. The sum is one bit
  // wider than an address so a burst running past 2**EXT_AW cannot alias low.
  function automatic logic burst_in_range(input logic [EXT_AW-1:0] ext,
                                          input logic [LEN_W-1:0]  len);
    logic [EXT_AW:0] end_addr;
    end_addr = {1'b0, ext} + (EXT_AW+1)'(len);
    return end_addr <= (EXT_AW+1)'(EXT_WORDS);
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Burst counter and address incrementer shared by loads and stores.
// The issue side produces the address of the word being requested this cycle;
// the completion side is the same information one cycle later, lined up with
// the 1-cycle read latency of whichever memory is the source.
module dma_addr_gen
  import ext_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [EXT_AW-1:0] ext_base,
  input  logic [LOC_AW-1:0] loc_base,
  input  logic [LEN_W-1:0]  len,
  output logic [EXT_AW-1:0] issue_ext,
  output logic [LOC_AW-1:0] issue_loc,
  output logic              last,
  output logic              comp_valid,
  output logic [EXT_AW-1:0] comp_ext,
  output logic [LOC_AW-1:0] comp_loc
);

  logic [LEN_W-1:0] idx;

  // Word index of the current issue; restarts for every accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + 1'b1;
    end
  end

  // Local addresses wrap modulo 2**LOC_AW by truncation; external addresses
  // cannot wrap because out-of-range bursts never reach the issue phase.
  assign issue_ext = ext_base + EXT_AW'(idx);
  assign issue_loc = loc_base + idx[LOC_AW-1:0];
  assign last      = (idx == (len - 1'b1));

  // Completion side: delayed copy of the issue strobe and addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_valid <= 1'b0;
      comp_ext   <= '0;
      comp_loc   <= '0;
    end else begin
      comp_valid <= step;
      comp_ext   <= issue_ext;
      comp_loc   <= issue_loc;
    end
  end

endmodule

// File: rtl/ext_mem_dma.sv
// External-memory DMA initiator: one command at a time, bursts of words
// between external memory and the local buffer, done pulse on completion.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_valid may
// be held or dropped freely while cmd_ready is low without effect.
module ext_mem_dma
  import ext_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [EXT_AW-1:0] cmd_ext_addr,
  input  logic [LOC_AW-1:0] cmd_loc_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [EXT_AW-1:0] mem_rd_addr,
  output logic              mem_wr_en,
  output logic [EXT_AW-1:0] mem_wr_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              loc_we,
  output logic [LOC_AW-1:0] loc_waddr,
  output logic [DW-1:0]     loc_wdata,
  output logic              loc_re,
  output logic [LOC_AW-1:0] loc_raddr,
  input  logic [DW-1:0]     loc_rdata
);

  dma_state_e        state, state_next;
  dma_dir_e          dir_q;
  logic [EXT_AW-1:0] ext_q;
  logic [LOC_AW-1:0] loc_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;

  logic              accept;
  logic              step;
  logic              last;
  logic              comp_valid;
  logic [EXT_AW-1:0] issue_ext, comp_ext;
  logic [LOC_AW-1:0] issue_loc, comp_loc;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign step      = (state == LOAD) || (state == STORE);

  // State register; reset returns to IDLE and abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: empty or out-of-range commands skip straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (cmd_valid) state_next = CHECK;
      CHECK: begin
        if ((len_q == '0) || !burst_in_range(ext_q, len_q)) begin
          state_next = DONE;
        end else if (dir_q == DIR_STORE) begin
          state_next = STORE;
        end else begin
          state_next = LOAD;
        end
      end
      LOAD:    if (last) state_next = DRAIN;
      STORE:   if (last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command fields are captured once on acceptance and held for the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_LOAD;
      ext_q <= '0;
      loc_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      dir_q <= dma_dir_e'(cmd_dir);
      ext_q <= cmd_ext_addr;
      loc_q <= cmd_loc_addr;
      len_q <= cmd_len;
    end
  end

  // Range verdict is decided in CHECK and held until the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == CHECK) begin
      err_q <= (len_q != '0) && !burst_in_range(ext_q, len_q);
    end
  end

  dma_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .step       (step),
    .ext_base   (ext_q),
    .loc_base   (loc_q),
    .len        (len_q),
    .issue_ext  (issue_ext),
    .issue_loc  (issue_loc),
    .last       (last),
    .comp_valid (comp_valid),
    .comp_ext   (comp_ext),
    .comp_loc   (comp_loc)
  );

  // Strobes derive from reset-cleared flops, so they fall as soon as rst_n
  // drops. Address/data buses are zero whenever their strobe is low.
  assign done        = (state == DONE);
  assign err         = done && err_q;

  assign mem_rd_en   = (state == LOAD);
  assign mem_rd_addr = mem_rd_en ? issue_ext : '0;
  assign loc_we      = comp_valid && (dir_q == DIR_LOAD);
  assign loc_waddr   = loc_we ? comp_loc : '0;
  assign loc_wdata   = loc_we ? mem_rdata : '0;

  assign loc_re      = (state == STORE);
  assign loc_raddr   = loc_re ? issue_loc : '0;
  assign mem_wr_en   = comp_valid && (dir_q == DIR_STORE);
  assign mem_wr_addr = mem_wr_en ? comp_ext : '0;
  assign mem_wdata   = mem_wr_en ? loc_rdata : '0;

endmodule
